// File: rtl/uart_tx_buffer.sv
// Transmit byte FIFO feeding Tx_uart: absorbs back-to-back writes and hands
// bytes out one frame at a time over the start/done handshake.
module uart_tx_buffer #(
  parameter int NB_BITS    = 8,
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [NB_BITS-1:0]    i_data,
  input  logic                  i_wr,
  input  logic                  i_tx_done,
  output logic [NB_BITS-1:0]    o_data,
  output logic                  o_tx_start,
  output logic [DEPTH_LOG2:0]   o_count,
  output logic                  o_empty,
  output logic                  o_full,
  output logic                  o_overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, START, WAIT} state_t;

  state_t                  state, state_nxt;
  logic [NB_BITS-1:0]      mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wr_ptr, rd_ptr;
  logic [DEPTH_LOG2:0]     count;
  logic                    wr_en, pop;

  // Full is judged on the registered count, so a pop on the same edge
  // cannot rescue a write that arrives while full.
  assign o_empty    = (count == '0);
  assign o_full     = (count == (DEPTH_LOG2+1)'(DEPTH));
  assign wr_en      = i_wr & ~o_full;
  assign o_count    = count;
  assign o_tx_start = (state == START);

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    case (state)
      IDLE:  if (!o_empty) begin
               pop       = 1'b1;
               state_nxt = START;
             end
      START: state_nxt = WAIT;
      WAIT:  if (i_tx_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (wr_en) mem[wr_ptr] <= i_data;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      o_data     <= '0;
      o_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (wr_en) wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
      if (pop) begin
        rd_ptr <= rd_ptr + DEPTH_LOG2'(1);
        o_data <= mem[rd_ptr];
      end
      case ({wr_en, pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
      if (i_wr && o_full) o_overflow <= 1'b1;
    end
  end

endmodule
